// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter; 10-bit frames, or 11-bit even-parity
// frames when UART_TX_PARITY_EN is defined. The line is registered one cycle behind the FSM.
module uart_tx_fifo #(
    parameter logic [13:0] KBAUD = 14'd10416,
    parameter int          DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    out_ready,
    output logic                    out_signal,
    output logic                    out_busy,
    output logic [$clog2(DEPTH):0]  out_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    state_t        state_q, state_d;
    logic [13:0]   cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          line_q, line_d;
    logic          push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign out_ready  = (level_q < LW'(DEPTH));
    assign out_level  = level_q;
    assign out_signal = line_q;
    assign out_busy   = (state_q != IDLE) || (level_q != '0);
    assign push       = in_valid && out_ready;
    assign bit_end    = (cnt_q == KBAUD - 14'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 14'd1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end
    end

    always_comb begin
        line_d = 1'b1;
        unique case (state_q)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_q[idx_q];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_d = parity_q;
`endif
            default: line_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            line_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            line_q   <= line_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed + random stimulus against a queue-based model of the FIFO and
// the expected per-cycle TX line (frames expanded to KBAUD samples per bit).
module tb_uart_tx_fifo;
    localparam int K = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready, out_signal, out_busy;
    logic [2:0] out_level;

    uart_tx_fifo #(.KBAUD(14'd4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .out_ready(out_ready), .out_signal(out_signal), .out_busy(out_busy),
        .out_level(out_level)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] mq[$];
    logic       exp_line[$];
    logic       exp_sig = 1'b1;
    int         rem = 0;

    task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
        int         pre;
        logic [7:0] b;
        if (!r) begin
            mq.delete();
            exp_line.delete();
            rem = 0;
            exp_sig = 1'b1;
        end else begin
            pre = mq.size();
            exp_sig = (exp_line.size() > 0) ? exp_line.pop_front() : 1'b1;
            if (rem > 0) rem--;
            if (rem == 0 && pre > 0) begin
                b = mq.pop_front();
                for (int j = 0; j < K; j++) exp_line.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < K; j++) exp_line.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
                for (int j = 0; j < K; j++) exp_line.push_back(^b);
`endif
                for (int j = 0; j < K; j++) exp_line.push_back(1'b1);
                rem = FRAME * K;
            end
            if (v && pre < DEPTH) mq.push_back(d);
        end
    endtask

    task automatic check();
        logic [2:0] lvl;
        logic       bsy;
        lvl = 3'(mq.size());
        bsy = (rem != 0) || (mq.size() != 0);
        tests++;
        assert (out_signal === exp_sig) else begin
            fails++; $error("FAIL line cyc=%0d got=%b exp=%b", cyc, out_signal, exp_sig);
        end
        tests++;
        assert (out_level === lvl) else begin
            fails++; $error("FAIL level cyc=%0d got=%0d exp=%0d", cyc, out_level, lvl);
        end
        tests++;
        assert (out_ready === (lvl < 3'(DEPTH))) else begin
            fails++; $error("FAIL ready cyc=%0d got=%b exp=%b", cyc, out_ready, lvl < 3'(DEPTH));
        end
        tests++;
        assert (out_busy === bsy) else begin
            fails++; $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, out_busy, bsy);
        end
    endtask

    // Drive at the falling edge, update the model on the rising edge, sample 1 ns later.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        rst_n    = r;
        @(posedge clk);
        model_edge(v, d, r);
        #1;
        cyc++;
        check();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (mq.size() != 0 || rem != 0); i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        tests++;
        assert (out_busy === 1'b0 && out_signal === 1'b1) else begin
            fails++; $error("FAIL drain_timeout busy=%b line=%b exp busy=0 line=1", out_busy, out_signal);
        end
    endtask

    initial begin
        logic [7:0] base;
        @(negedge clk);
        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 8'hAA, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // Single byte 0x55 from idle
        step(1'b1, 8'h55, 1'b1);
        drain();

        // Back-to-back frames
        step(1'b1, 8'hA3, 1'b1);
        step(1'b1, 8'h0F, 1'b1);
        drain();

        // Hold valid with six distinct bytes during a frame
        base = 8'($urandom_range(0, 255));
        step(1'b1, base, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 6; i++) step(1'b1, base + 8'(i * 37), 1'b1);
        drain();

        // Keep the FIFO full across several stop-end pops
        for (int i = 0; i < 4 * FRAME * K; i++) step(1'b1, 8'($urandom), 1'b1);
        drain();

`ifdef UART_TX_PARITY_EN
        step(1'b1, 8'h07, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        drain();
`endif

        // Random traffic
        for (int i = 0; i < 2000; i++) step($urandom_range(0, 9) < 3, 8'($urandom), 1'b1);
        drain();

        // Reset during bit 3 of 0xFF with two bytes queued
        step(1'b1, 8'hFF, 1'b1);
        step(1'b1, 8'($urandom), 1'b1);
        step(1'b1, 8'($urandom), 1'b1);
        for (int i = 0; i < 4 * K; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        tests++;
        assert (out_signal === 1'b1 && out_level === 3'd0 && out_busy === 1'b0) else begin
            fails++; $error("FAIL mid_reset line=%b level=%0d busy=%b exp 1/0/0", out_signal, out_level, out_busy);
        end
        for (int i = 0; i < 20 * K; i++) step(1'b0, 8'h00, 1'b1);

        // Traffic resumes normally after reset
        step(1'b1, 8'h3C, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
